// File: rtl/rv32_pkg.sv
// Shared load/store encodings and the data-memory responder FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package rv32_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_RSV = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when the access size is reserved or the address is not naturally aligned.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Lane steering: store byte-enables/data placement and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; reserved sizes give zero enables and zero load data.
module lane_align
  import rv32_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicate store data across lanes so the enables alone pick the lane;
  // pick the addressed lane(s) out of the load word and extend.
  always_comb begin
    st_be   = 4'b0000;
    st_word = 32'h0;
    ld_data = 32'h0;
    ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (size)
      SIZE_B: begin
        st_be   = 4'b0001 << addr_lo;
        st_word = {4{st_data[7:0]}};
        ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      end
      SIZE_H: begin
        st_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
        ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      end
      SIZE_W: begin
        st_be   = 4'b1111;
        st_word = st_data;
        ld_data = ld_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data memory: accepts one load/store, responds after LATENCY wait states.
// Latency: rsp_valid first asserts LATENCY+1 cycles after the accept cycle.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module dmem_resp
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        we_q, uns_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, enter_resp;

  logic [31:0] mem [DEPTH_WORDS];

  // Operation fields: with zero wait states the commit happens on the accept
  // edge itself, so the live request is used while still in IDLE.
  logic [31:0] op_addr, op_wdata;
  logic [1:0]  op_size;
  logic        op_we, op_uns, op_err;
  logic [AW-1:0] widx;
  logic [3:0]  st_be;
  logic [31:0] st_word, ld_data, rd_word;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign op_addr  = (state_q == IDLE) ? req_addr     : addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
  assign op_size  = (state_q == IDLE) ? req_size     : size_q;
  assign op_we    = (state_q == IDLE) ? req_we       : we_q;
  assign op_uns   = (state_q == IDLE) ? req_unsigned : uns_q;

  assign op_err  = size_misaligned(op_size, op_addr[1:0]) ||
                   ({2'b00, op_addr[31:2]} >= DEPTH_WORDS);
  assign widx    = op_addr[AW+1:2];
  assign rd_word = mem[widx];

  lane_align u_lane (
    .addr_lo     (op_addr[1:0]),
    .size        (op_size),
    .is_unsigned (op_uns),
    .st_data     (op_wdata),
    .ld_word     (rd_word),
    .st_be       (st_be),
    .st_word     (st_word),
    .ld_data     (ld_data)
  );

  // Next-state and wait-state counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
      end
      if (enter_resp) begin
        err_q   <= op_err;
        rdata_q <= (op_we || op_err) ? 32'h0 : ld_data;
      end
    end
  end

  // Storage: lanes commit on the edge entering RESP; reset never clears contents.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_we && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[widx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  int total = 0;
  int bad   = 0;

  // Byte-addressed little-endian reference memory.
  logic [7:0] mbytes [0:4*DEPTH-1];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference behaviour: decide error, apply store, or assemble/extend load.
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns);
    exp_t e;
    int n;
    logic [31:0] v;
    e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || ((addr >> 2) >= 32'(DEPTH));
    e.rdata = 32'h0;
    if (!e.err) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) mbytes[addr + 32'(i)] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mbytes[addr + 32'(i)]) << (8*i));
        if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Compare every response cycle against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with 0 outstanding, want 0");
      end else begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold,
                        output logic [31:0] got_rdata, output logic got_err);
    int cyc;
    bit ok;
    got_rdata = 32'hx;
    got_err   = 1'bx;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; rsp_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: req_ready=0 for 20 cycles, want 1");
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(we, addr, wdata, size, uns));
    @(posedge clk); #1 req_valid = 1'b0;
    cyc = 1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
      @(posedge clk);
      cyc++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rsp_timeout: rsp_valid=0 for 40 cycles, want 1");
      exp_q.delete();
      return;
    end
    chk("latency", 32'(cyc), 32'(LAT + 1));
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rdata_stable", rsp_rdata, got_rdata);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic abort_store(input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    bit seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata;
    req_size = 2'd2; req_unsigned = 1'b0; rsp_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL abort_accept_timeout: req_ready=0 for 20 cycles, want 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_busy", 32'(rsp_valid | req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    // word store then word load
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, rd, er);
    chk("st_w_rdata", rd, 32'h0);
    chk("st_w_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
    chk("ld_w_lit", rd, 32'hDEADBEEF);
    chk("ld_w_err", 32'(er), 32'd0);

    // byte and half lane loads
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, rd, er);
    chk("ld_b_signed_lit", rd, 32'hFFFFFFDE);
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, rd, er);
    chk("ld_b_unsigned_lit", rd, 32'h000000DE);
    do_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0, rd, er);
    chk("ld_h_signed_lit", rd, 32'hFFFFDEAD);
    do_req(1'b0, 32'h10, 32'h0, 2'd1, 1'b1, 0, rd, er);
    chk("ld_h_lo_unsigned_lit", rd, 32'h0000BEEF);
    do_req(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 0, rd, er);
    chk("ld_b_lane0_lit", rd, 32'hFFFFFFEF);

    // byte store merge
    do_req(1'b1, 32'h11, 32'h00000055, 2'd0, 1'b0, 0, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
    chk("merge_lit", rd, 32'hDEAD55EF);

    // half store at upper lanes
    do_req(1'b1, 32'h16, 32'h0000A1B2, 2'd1, 1'b0, 0, rd, er);
    do_req(1'b1, 32'h14, 32'h0000C3D4, 2'd1, 1'b0, 0, rd, er);
    do_req(1'b0, 32'h14, 32'h0, 2'd2, 1'b0, 0, rd, er);
    chk("half_merge_lit", rd, 32'hA1B2C3D4);

    // misaligned and out-of-range
    do_req(1'b1, 32'h20, 32'hA5A5A5A5, 2'd2, 1'b0, 0, rd, er);
    do_req(1'b1, 32'h22, 32'h12345678, 2'd2, 1'b0, 0, rd, er);
    chk("misal_st_err_lit", 32'(er), 32'd1);
    chk("misal_st_rdata_lit", rd, 32'h0);
    do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, rd, er);
    chk("misal_unchanged_lit", rd, 32'hA5A5A5A5);
    do_req(1'b0, 32'(4*DEPTH), 32'h0, 2'd2, 1'b0, 0, rd, er);
    chk("oob_err_lit", 32'(er), 32'd1);
    chk("oob_rdata_lit", rd, 32'h0);
    do_req(1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0, rd, er);
    chk("misal_h_err_lit", 32'(er), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0, rd, er);
    chk("size3_err_lit", 32'(er), 32'd1);
    do_req(1'b0, 32'(4*DEPTH - 4), 32'h0, 2'd2, 1'b0, 0, rd, er);
    chk("last_word_err_lit", 32'(er), 32'd0);

    // response backpressure
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, rd, er);
    chk("bp_rdata_lit", rd, 32'hDEAD55EF);

    // reset mid-store
    do_req(1'b1, 32'h40, 32'h11223344, 2'd2, 1'b0, 0, rd, er);
    abort_store(32'h40, 32'hCAFEF00D);
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, rd, er);
    chk("abort_kept_lit", rd, 32'h11223344);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
